seq_chunk_adder: RTL and testbench
==================================

// Module: seq_chunk_adder
// PURPOSE
//  Multi-cycle, parametrised ripple-carry adder: WIDTH-bit a + b + cin in CHUNK-bit slices, one slice per clock.
//  Reports sum, the full per-bit carry vector cout[WIDTH-1:0] and the final carry-out.
//  Sits between wide-operand producers and consumers that tolerate latency.
//  Trades latency for a short combinational carry path.
//  Valid/ready handshake on both sides.
// PARAMETERS
//  WIDTH  100  operand/sum/carry-vector width, >=1
//  CHUNK  25   bits added per cycle, 1..WIDTH; NCHUNK = ceil(WIDTH/CHUNK)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operands presented
//  in_ready   out  1      block can accept operands
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry into bit 0
//  out_valid  out  1      result available
//  out_ready  in   1      consumer takes result
//  sum        out  WIDTH  a+b+cin, low WIDTH bits
//  cout       out  WIDTH  cout[i] = carry out of bit i
//  carry_out  out  1      equals cout[WIDTH-1]
// BEHAVIOUR
//  Reset values:
//   - state=IDLE, in_ready=1, out_valid=0
//   - sum=0, cout=0, carry_out=0
//   - chunk index=0, running carry=0
//  FSM IDLE -> CALC -> DONE -> IDLE:
//   - IDLE: in_ready=1. On in_valid: register a, b, cin; clear sum/cout; idx=0; go to CALC.
//   - CALC: in_ready=0. Each cycle add slice idx (bits idx*CHUNK .. min((idx+1)*CHUNK, WIDTH)-1):
//     - bit i: s=a^b^c, co=a&b | a&c | b&c.
//     - c = cin for bit 0, else cout[i-1].
//     - Carry chains from slice to slice through a registered running carry.
//     - After slice NCHUNK-1, go to DONE.
//   - DONE: out_valid=1; sum/cout/carry_out held stable. On out_ready, go to IDLE next cycle.
//  Timing and handshake:
//   - out_valid rises exactly NCHUNK cycles after the accept edge.
//   - Throughput: one op per NCHUNK+2 cycles with out_ready held high.
//   - in_valid while in_ready=0 is ignored; operands are not captured.
//   - No accept in the same cycle as a result handoff.
//  Boundary conditions:
//   - Last slice partial (WIDTH % CHUNK != 0): only valid bits computed; no out-of-range indexing.
//   - CHUNK==WIDTH: single CALC cycle.
//   - CHUNK==1: pure bit-serial.
//   - Full-width overflow is not an error: carry_out=1, sum wraps mod 2^WIDTH.
//   - Input ports a/b/cin changing during CALC have no effect (registered copies used).
//   - rst in any state (incl. mid-CALC, DONE under backpressure): partial result discarded, all outputs return to reset values next cycle.
//   - sum/cout during CALC are internal partial values, not meaningful while out_valid=0.
// CONFIGURATION
//  ADDER_SUB_EN defined:
//   - Adds port in_sub (in, 1), captured with the operands.
//   - in_sub=1: computes a + ~b + ~cin, i.e. a-b-borrow with cin as borrow-in.
//   - carry_out=1 means no borrow.
//   - Adds port ovf (out, 1, reset 0): signed overflow = cout[WIDTH-1]^cout[WIDTH-2] (WIDTH>=2), 0 when WIDTH=1; valid with out_valid.
//   - in_sub=0: identical to plain add.
//  ADDER_SUB_EN undefined: no in_sub/ovf ports; add only.
// TESTING
//  Defaults (WIDTH=100, CHUNK=25, NCHUNK=4) unless noted.
//  1. a=0, b=0, cin=1 -> sum=1, cout=0, carry_out=0; out_valid exactly 4 cycles after accept.
//  2. a=5, b=3, cin=0 -> sum=8, cout=0x7, carry_out=0.
//  3. a=all-ones, b=0, cin=1 -> sum=0, cout=all-ones, carry_out=1 (carry crosses every slice boundary).
//  4. out_ready=0 for 10 cycles in DONE -> out_valid stays 1, sum/cout unchanged, in_ready=0; new in_valid not captured; out_ready=1 -> in_ready=1 next cycle.
//  5. rst asserted on 2nd CALC cycle -> next cycle out_valid=0, in_ready=1, sum=0, cout=0; fresh op then completes correctly.
//  6. WIDTH=7, CHUNK=3: a=0x7F, b=1, cin=0 -> 3 CALC cycles, sum=0, carry_out=1.
//     With ADDER_SUB_EN, default params: a=10, b=3, cin=0, in_sub=1 -> sum=7, carry_out=1, ovf=0.

Source files
------------

// File: rtl/seq_chunk_adder_if.sv
// Handshake and operand/result bus for seq_chunk_adder; master is the requester/consumer side.
// With ADDER_SUB_EN defined the bus also carries in_sub and ovf.
interface seq_chunk_adder_if #(
    parameter int WIDTH = 100
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] cout;
    logic             carry_out;
`ifdef ADDER_SUB_EN
    logic             in_sub;
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, carry_out
`ifdef ADDER_SUB_EN
        , output in_sub
        , input  ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, carry_out
`ifdef ADDER_SUB_EN
        , input  in_sub
        , output ovf
`endif
    );
endinterface

// File: rtl/seq_chunk_adder.sv
// Ripple-carry a+b+cin over WIDTH bits, CHUNK bits per clock; optional subtract via ADDER_SUB_EN.
// Latency: out_valid rises NCHUNK cycles after the accept edge; one op per NCHUNK+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, so no accept during handoff.
module seq_chunk_adder #(
    parameter int WIDTH = 100,
    parameter int CHUNK = 25
) (
    input  logic               clk,
    input  logic               rst,
    seq_chunk_adder_if.slave   bus
);
    localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] cout_q;
    logic             c_run;
    logic [IDXW-1:0]  idx;
    logic             accept;
    logic             last;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // Subtraction is folded in at capture time, so the slice adder never sees in_sub.
`ifdef ADDER_SUB_EN
    assign b_eff   = bus.in_sub ? ~bus.b : bus.b;
    assign cin_eff = bus.cin ^ bus.in_sub;
`else
    assign b_eff   = bus.b;
    assign cin_eff = bus.cin;
`endif

    assign last = (int'(idx) == NCHUNK - 1);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        accept        = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Current slice: operands shifted down to bit 0, results shifted back up.
    // Bits of a partial last slice past WIDTH-1 are zero-filled and fall off the left shift.
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] s_ins;
    logic [WIDTH-1:0] c_ins;
    logic [CHUNK-1:0] s_sl;
    logic [CHUNK-1:0] c_sl;
    int               base;

    always_comb begin
        logic c;
        logic c_next;
        base  = int'(idx) * CHUNK;
        a_sh  = a_q >> base;
        b_sh  = b_q >> base;
        s_sl  = '0;
        c_sl  = '0;
        c     = c_run;
        for (int j = 0; j < CHUNK; j++) begin
            c_next  = (a_sh[j] & b_sh[j]) | (a_sh[j] & c) | (b_sh[j] & c);
            s_sl[j] = a_sh[j] ^ b_sh[j] ^ c;
            c_sl[j] = c_next;
            c       = c_next;
        end
        s_ins            = '0;
        c_ins            = '0;
        s_ins[CHUNK-1:0] = s_sl;
        c_ins[CHUNK-1:0] = c_sl;
        s_ins            = s_ins << base;
        c_ins            = c_ins << base;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            cout_q <= '0;
            c_run  <= 1'b0;
            idx    <= '0;
        end else if (accept) begin
            a_q    <= bus.a;
            b_q    <= b_eff;
            c_run  <= cin_eff;
            sum_q  <= '0;
            cout_q <= '0;
            idx    <= '0;
        end else if (state == CALC) begin
            sum_q  <= sum_q | s_ins;
            cout_q <= cout_q | c_ins;
            c_run  <= c_sl[CHUNK-1];
            idx    <= last ? '0 : idx + 1'b1;
        end
    end

    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.carry_out = cout_q[WIDTH-1];

`ifdef ADDER_SUB_EN
    generate
        if (WIDTH >= 2) begin : g_ovf
            assign bus.ovf = cout_q[WIDTH-1] ^ cout_q[WIDTH-2];
        end else begin : g_ovf1
            assign bus.ovf = 1'b0;
        end
    endgenerate
`endif
endmodule

// File: tb/tb_seq_chunk_adder.sv
// Randomized and directed checks of seq_chunk_adder (100/25 and 7/3 configurations) against an arithmetic model.
module tb_seq_chunk_adder;
    localparam int W  = 100;
    localparam int C  = 25;
    localparam int N  = 4;
    localparam int WS = 7;
    localparam int CS = 3;
    localparam int NS = 3;
`ifdef ADDER_SUB_EN
    localparam bit HAS_SUB = 1'b1;
`else
    localparam bit HAS_SUB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_chunk_adder_if #(.WIDTH(W))  bus0 ();
    seq_chunk_adder_if #(.WIDTH(WS)) bus1 ();

    seq_chunk_adder #(.WIDTH(W),  .CHUNK(C))  u_dut   (.clk(clk), .rst(rst), .bus(bus0.slave));
    seq_chunk_adder #(.WIDTH(WS), .CHUNK(CS)) u_small (.clk(clk), .rst(rst), .bus(bus1.slave));

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Plain-integer reference: full sum, carries from a^b^sum, signed overflow from operand/result signs.
    task automatic ref_add(input logic [127:0] a, input logic [127:0] b, input logic cin, input logic sub,
                           input int w, output logic [127:0] s, output logic [127:0] cv,
                           output logic co, output logic ov);
        logic [127:0] mask;
        logic [127:0] bb;
        logic [127:0] full;
        mask = (128'd1 << w) - 128'd1;
        bb   = (sub ? ~b : b) & mask;
        full = (a & mask) + bb + 128'(cin ^ sub);
        s    = full & mask;
        co   = full[w];
        cv   = ((a ^ bb ^ full) >> 1) & mask;
        ov   = (w >= 2) && (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
    endtask

    function automatic logic [127:0] rnd_val();
        logic [127:0] r;
        case ($urandom_range(0, 4))
            0:       r = '1;
            1:       r = '0;
            default: r = {$urandom, $urandom, $urandom, $urandom};
        endcase
        return r;
    endfunction

    task automatic run_main(input logic [127:0] a, input logic [127:0] b, input logic cin,
                            input logic sub, input int hold, input string tag);
        logic [127:0] es, ec, junk;
        logic         eco, eov;
        int           lat;
        ref_add(a, b, cin, sub, W, es, ec, eco, eov);
        @(negedge clk);
        check({tag, ".in_ready"}, 128'(bus0.in_ready), 128'(1));
        bus0.in_valid = 1'b1;
        bus0.a        = a[W-1:0];
        bus0.b        = b[W-1:0];
        bus0.cin      = cin;
`ifdef ADDER_SUB_EN
        bus0.in_sub   = sub;
`endif
        @(negedge clk);
        junk     = {$urandom, $urandom, $urandom, $urandom};
        bus0.a   = junk[W-1:0];
        bus0.b   = ~junk[W-1:0];
        bus0.cin = ~cin;
        lat = 0;
        while (bus0.out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, 128'(lat), 128'(N));
        check({tag, ".sum"}, 128'(bus0.sum), es);
        check({tag, ".cout"}, 128'(bus0.cout), ec);
        check({tag, ".carry_out"}, 128'(bus0.carry_out), 128'(eco));
`ifdef ADDER_SUB_EN
        check({tag, ".ovf"}, 128'(bus0.ovf), 128'(eov));
`endif
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, ".hold_valid"}, 128'(bus0.out_valid), 128'(1));
            check({tag, ".hold_in_ready"}, 128'(bus0.in_ready), 128'(0));
            check({tag, ".hold_sum"}, 128'(bus0.sum), es);
            check({tag, ".hold_cout"}, 128'(bus0.cout), ec);
        end
        bus0.in_valid  = 1'b0;
        bus0.out_ready = 1'b1;
        @(negedge clk);
        bus0.out_ready = 1'b0;
        check({tag, ".after_valid"}, 128'(bus0.out_valid), 128'(0));
        check({tag, ".after_in_ready"}, 128'(bus0.in_ready), 128'(1));
    endtask

    task automatic run_small(input logic [127:0] a, input logic [127:0] b, input logic cin,
                             input logic sub, input string tag);
        logic [127:0] es, ec;
        logic         eco, eov;
        int           lat;
        ref_add(a, b, cin, sub, WS, es, ec, eco, eov);
        @(negedge clk);
        bus1.in_valid = 1'b1;
        bus1.a        = a[WS-1:0];
        bus1.b        = b[WS-1:0];
        bus1.cin      = cin;
`ifdef ADDER_SUB_EN
        bus1.in_sub   = sub;
`endif
        @(negedge clk);
        bus1.in_valid = 1'b0;
        bus1.a        = ~a[WS-1:0];
        lat = 0;
        while (bus1.out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, 128'(lat), 128'(NS));
        check({tag, ".sum"}, 128'(bus1.sum), es);
        check({tag, ".cout"}, 128'(bus1.cout), ec);
        check({tag, ".carry_out"}, 128'(bus1.carry_out), 128'(eco));
`ifdef ADDER_SUB_EN
        check({tag, ".ovf"}, 128'(bus1.ovf), 128'(eov));
`endif
        bus1.out_ready = 1'b1;
        @(negedge clk);
        bus1.out_ready = 1'b0;
        check({tag, ".after_in_ready"}, 128'(bus1.in_ready), 128'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".out_valid"}, 128'(bus0.out_valid), 128'(0));
        check({tag, ".in_ready"}, 128'(bus0.in_ready), 128'(1));
        check({tag, ".sum"}, 128'(bus0.sum), 128'(0));
        check({tag, ".cout"}, 128'(bus0.cout), 128'(0));
        check({tag, ".carry_out"}, 128'(bus0.carry_out), 128'(0));
`ifdef ADDER_SUB_EN
        check({tag, ".ovf"}, 128'(bus0.ovf), 128'(0));
`endif
    endtask

    initial begin
        logic [127:0] ra, rb;
        logic         rs;
        rst = 1'b1;
        bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0; bus0.cin = 1'b0; bus0.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.out_ready = 1'b0;
`ifdef ADDER_SUB_EN
        bus0.in_sub = 1'b0;
        bus1.in_sub = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        run_main(128'd0, 128'd0, 1'b1, 1'b0, 0, "zero_cin");
        run_main(128'd5, 128'd3, 1'b0, 1'b0, 0, "five_three");
        run_main({28'd0, {W{1'b1}}}, 128'd0, 1'b1, 1'b0, 0, "ones_ripple");
        run_main(128'd123456789, 128'd987654321, 1'b0, 1'b0, 10, "backpressure");
        run_small(128'h7F, 128'd1, 1'b0, 1'b0, "small_wrap");
        if (HAS_SUB) run_main(128'd10, 128'd3, 1'b0, 1'b1, 0, "sub_10_3");

        // Reset on the second CALC cycle, then a fresh op.
        @(negedge clk);
        bus0.in_valid = 1'b1; bus0.a = '1; bus0.b = '1; bus0.cin = 1'b1;
        @(negedge clk);
        bus0.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("rst_calc");
        run_main(128'd77, 128'd23, 1'b1, 1'b0, 0, "after_rst_calc");

        // Reset while stalled in DONE.
        @(negedge clk);
        bus0.in_valid = 1'b1; bus0.a = '1; bus0.b = '1; bus0.cin = 1'b0;
        @(negedge clk);
        bus0.in_valid = 1'b0;
        repeat (N + 2) @(negedge clk);
        check("rst_done.pre_valid", 128'(bus0.out_valid), 128'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("rst_done");

        for (int i = 0; i < 40; i++) begin
            ra = rnd_val() & ((128'd1 << W) - 128'd1);
            rb = rnd_val() & ((128'd1 << W) - 128'd1);
            rs = HAS_SUB ? 1'($urandom_range(0, 1)) : 1'b0;
            run_main(ra, rb, 1'($urandom_range(0, 1)), rs, $urandom_range(0, 3), "rand_main");
        end
        for (int i = 0; i < 40; i++) begin
            ra = 128'($urandom_range(0, 127));
            rb = 128'($urandom_range(0, 127));
            rs = HAS_SUB ? 1'($urandom_range(0, 1)) : 1'b0;
            run_small(ra, rb, 1'($urandom_range(0, 1)), rs, "rand_small");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
